uart_rx_fifo_if: RTL and testbench

// - 8N1 UART receiver with an RX FIFO; CPU-side counterpart of the SoC UART transmitter output.
// - Sits in the soft-CPU domain (clk = clk_8mhz); i_rxd comes from a cartridge-port pin.
// - Exposes a first-word-fall-through byte stream plus sticky error flags to the CPU register block.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync_fifo.sv | 69 ++++++
 rtl/uart_rx_fifo_if.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_fifo_if.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Imported by the receiver top and its FIFO.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through byte FIFO for the UART receiver.
// Push and pop may coincide at any fill level, including when full.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DW = UART_DATA_BITS,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          valid,
  output logic [AW:0]   level,
  output logic          drop
);

  localparam logic [AW:0] DEPTH =
    (AW+1)'(2**AW);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full  = (level == DEPTH);
  assign empty = (level == '0);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign valid = !empty;
  assign rdata = empty ? '0 : mem[rptr];

  // Storage array; not reset, reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers and registered fill count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo_if.sv
// 8N1 UART receiver feeding an RX FIFO.
// Sticky frame/overrun flags for the CPU register block.
module uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 69,
  parameter int FIFO_AW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_rxd,
  output logic [7:0]         o_rdata,
  output logic               o_valid,
  input  logic               i_pop,
  output logic [FIFO_AW:0]   o_level,
  output logic               o_frame_err,
  output logic               o_overrun,
  input  logic               i_clr_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);

  logic        rx_m;
  logic        rx_s;

  rx_state_e   state;
  rx_state_e   state_nxt;
  logic [CW-1:0] bcnt;
  logic [CW-1:0] bcnt_nxt;
  logic [2:0]  idx;
  logic [2:0]  idx_nxt;
  logic [7:0]  sh;
  logic [7:0]  sh_nxt;

  logic        push;
  logic        ferr_set;
  logic        drop;

  // Two-flop synchroniser, idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rxd;
      rx_s <= rx_m;
    end
  end

  // Receiver state, bit timer and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bcnt  <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
      idx   <= idx_nxt;
      sh    <= sh_nxt;
    end
  end

  // Frame sequencing; the timer restarts on every state change.
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt + 1'b1;
    idx_nxt   = idx;
    sh_nxt    = sh;
    push      = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      IDLE: begin
        bcnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = START;
        end
      end
      START: begin
        if (bcnt == HALF) begin
          bcnt_nxt  = '0;
          idx_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bcnt == LAST) begin
          bcnt_nxt = '0;
          sh_nxt   = {rx_s, sh[7:1]};
          idx_nxt  = idx + 3'd1;
          if (idx == 3'd7) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (bcnt == LAST) begin
          bcnt_nxt = '0;
          if (rx_s) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        bcnt_nxt = '0;
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        bcnt_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Sticky error flags; a new error wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (ferr_set) begin
        o_frame_err <= 1'b1;
      end else if (i_clr_err) begin
        o_frame_err <= 1'b0;
      end
      if (drop) begin
        o_overrun <= 1'b1;
      end else if (i_clr_err) begin
        o_overrun <= 1'b0;
      end
    end
  end

  uart_sync_fifo #(
    .DW (UART_DATA_BITS),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (sh),
    .pop   (i_pop),
    .rdata (o_rdata),
    .valid (o_valid),
    .level (o_level),
    .drop  (drop)
  );

endmodule

// File: tb/tb_uart_rx_fifo_if.sv
// Directed bench for the UART receiver and RX FIFO.
// Eight clocks per bit, four-entry FIFO.
module tb_uart_rx_fifo_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rdata;
  logic       valid;
  logic       pop;
  logic [2:0] level;
  logic       ferr;
  logic       ovr;
  logic       clr;

  int passed = 0;
  int total  = 0;

  uart_rx_fifo_if #(
    .CLKS_PER_BIT (8),
    .FIFO_AW      (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rxd       (rxd),
    .o_rdata     (rdata),
    .o_valid     (valid),
    .i_pop       (pop),
    .o_level     (level),
    .o_frame_err (ferr),
    .o_overrun   (ovr),
    .i_clr_err   (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h",
                tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_head(input logic [7:0] d);
    rxd = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(8);
    end
  endtask

  task automatic send(input logic [7:0] d,
                      input logic stp);
    send_head(d);
    rxd = stp;
    tick(8);
  endtask

  task automatic pop1;
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
  endtask

  task automatic clr1;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  logic [7:0] bv;

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    pop = 1'b0;
    clr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_ferr", 32'(ferr), 0);
    chk("rst_ovr", 32'(ovr), 0);
    tick(4);

    send_head(8'hA5);
    rxd = 1'b1;
    tick(6);
    chk("a5_early", 32'(valid), 0);
    tick(1);
    chk("a5_valid", 32'(valid), 1);
    chk("a5_rdata", 32'(rdata), 32'hA5);
    chk("a5_level", 32'(level), 1);
    tick(1);
    pop1;
    chk("a5_popped", 32'(valid), 0);
    tick(4);

    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(20);
    chk("gl_valid", 32'(valid), 0);
    chk("gl_ferr", 32'(ferr), 0);

    send(8'h3C, 1'b0);
    chk("fe_flag", 32'(ferr), 1);
    chk("fe_empty", 32'(valid), 0);
    tick(40);
    rxd = 1'b1;
    tick(16);
    send(8'h55, 1'b1);
    tick(4);
    chk("fe_level", 32'(level), 1);
    chk("fe_rdata", 32'(rdata), 32'h55);
    chk("fe_sticky", 32'(ferr), 1);
    pop1;
    clr1;
    chk("fe_clr", 32'(ferr), 0);
    chk("fe_lvl0", 32'(level), 0);

    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b1);
      tick(2);
    end
    chk("ov_level", 32'(level), 4);
    chk("ov_flag", 32'(ovr), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ov_head", 32'(rdata), i);
      pop1;
    end
    chk("ov_drain", 32'(valid), 0);
    clr1;
    chk("ov_clr", 32'(ovr), 0);

    for (int i = 1; i <= 4; i++) begin
      bv = 8'(i * 8'h11);
      send(bv, 1'b1);
      tick(2);
    end
    chk("pp_full", 32'(level), 4);
    send_head(8'h99);
    rxd = 1'b1;
    tick(6);
    pop = 1'b1;
    tick(1);
    pop = 1'b0;
    chk("pp_level", 32'(level), 4);
    chk("pp_ovr", 32'(ovr), 0);
    chk("pp_head", 32'(rdata), 32'h22);
    tick(3);
    chk("pp_h2", 32'(rdata), 32'h22);
    pop1;
    chk("pp_h3", 32'(rdata), 32'h33);
    pop1;
    chk("pp_h4", 32'(rdata), 32'h44);
    pop1;
    chk("pp_tail", 32'(rdata), 32'h99);
    pop1;
    chk("pp_empty", 32'(level), 0);

    send(8'h77, 1'b1);
    tick(2);
    send(8'h00, 1'b0);
    rxd = 1'b1;
    tick(4);
    chk("rs_pre_lvl", 32'(level), 1);
    chk("rs_pre_fe", 32'(ferr), 1);
    bv = 8'h5A;
    rxd = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      rxd = bv[i];
      tick(8);
    end
    rxd = bv[4];
    tick(4);
    rst = 1'b1;
    rxd = 1'b1;
    tick(2);
    rst = 1'b0;
    chk("rs_valid", 32'(valid), 0);
    chk("rs_level", 32'(level), 0);
    chk("rs_rdata", 32'(rdata), 0);
    chk("rs_ferr", 32'(ferr), 0);
    chk("rs_ovr", 32'(ovr), 0);
    tick(4);
    send(8'h81, 1'b1);
    tick(2);
    chk("rs_81", 32'(rdata), 32'h81);
    chk("rs_81_lvl", 32'(level), 1);

    $display("%0d/%0d checks passed",
             passed, total);
    $finish;
  end

endmodule
